intr_req_ctrl: RTL and testbench
================================

INTR_REQ_CTRL -- requirements
Module: intr_req_ctrl

Interface
REQ-001 Parameter: NUM_SRC, default 4, number of interrupt sources.
REQ-002 Parameter: ACK_TIMEOUT, default 7, cycles to wait for CPU acknowledge before re-arbitrating.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 irq_src  input  NUM_SRC  raw peripheral interrupt lines, synchronous to clk, rising-edge triggered.
REQ-006 irq_mask  input  NUM_SRC  1 = source masked (kept pending, never requested).
REQ-007 cpu_busy  input  1  CPU is executing an interrupt service.
REQ-008 cpu_ovf  input  1  CPU arithmetic-overflow exception this cycle.
REQ-009 intr_ack  input  1  CPU loaded the interrupt-service PC (one-cycle pulse).
REQ-010 ints_end  input  1  CPU finished the interrupt service routine (one-cycle pulse).
REQ-011 external_intr  output  1  one-cycle interrupt request pulse to the CPU.
REQ-012 intr_id  output  log2(NUM_SRC)  index of the source being requested/serviced.
REQ-013 pending  output  NUM_SRC  latched pending bits.
REQ-014 in_service  output  1  a granted interrupt is being serviced.

Function
REQ-015 A rising edge on irq_src[i] (previous sampled 0, current 1) SHALL set pending[i] on the next clock edge.
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_ACK, SERVICE.
REQ-017 IDLE -> ISSUE when (pending & ~irq_mask) != 0 and cpu_busy == 0; intr_id latches the lowest set index of (pending & ~irq_mask).
REQ-018 ISSUE SHALL assert external_intr for exactly that one cycle, clear the timeout counter and go to WAIT_ACK.
REQ-019 WAIT_ACK: intr_ack with no cpu_ovf seen since ISSUE -> SERVICE, clear pending[intr_id], assert in_service.
REQ-020 WAIT_ACK: cpu_ovf in ISSUE or WAIT_ACK -> IDLE with pending unchanged; the CPU vectors to the overflow handler, so the request is retried.
REQ-021 WAIT_ACK: 3-bit counter increments each cycle; at ACK_TIMEOUT without intr_ack -> IDLE with pending unchanged.
REQ-022 SERVICE: ints_end -> IDLE, deassert in_service; no new ISSUE earlier than the cycle after IDLE is entered.
REQ-023 Same-cycle set and clear of one pending bit (new edge during grant): set wins, bit stays 1.
REQ-024 Masking a source after ISSUE SHALL NOT cancel the outstanding request; the mask applies only at the next arbitration.
REQ-025 intr_id SHALL be held constant from ISSUE until the FSM returns to IDLE.
REQ-026 Edges on sources already pending SHALL be absorbed (no counting); edges during SERVICE SHALL be latched.

Reset
REQ-027 With rst high at a clock edge: state = IDLE, pending = 0, edge-detect history = 0, counter = 0, external_intr = 0, intr_id = 0, in_service = 0.
REQ-028 Reset asserted mid-operation (any state) SHALL abandon the request without an external_intr pulse on the reset cycle.
REQ-029 A source held high through reset release SHALL NOT create a pending bit until it falls and rises again.

Structure
REQ-030 Shared package intr_pkg SHALL hold the state enumeration, NUM_SRC default, ACK_TIMEOUT default and the overflow/external vector constants 0x300/0x200.
REQ-031 Edge detection SHALL be a sub-module irq_edge_det (NUM_SRC-wide register + rising-edge compare).
REQ-032 Priority encoder and FSM SHALL live in intr_req_ctrl.

Verification
REQ-033 Rising edge irq_src[2], mask 0 -> pending[2] next cycle, external_intr one cycle later, intr_id = 2; ack -> pending[2] = 0, in_service = 1.
REQ-034 Simultaneous edges on src 1 and 3 -> intr_id = 1 first; after ints_end, intr_id = 3 requested.
REQ-035 cpu_ovf pulsed one cycle after external_intr, then ack -> return to IDLE, pending kept, re-ISSUE once cpu_busy = 0.
REQ-036 No intr_ack for 7 cycles after ISSUE -> IDLE, second external_intr pulse with the same intr_id.
REQ-037 irq_mask[0] = 1 with pending[0] = 1 -> no request; clearing the mask -> request intr_id = 0.
REQ-038 rst in WAIT_ACK -> all outputs 0 next cycle; source held high across reset -> no pending bit.

Source files
------------

// File: rtl/intr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intr_pkg
// Description : Shared constants for the interrupt request controller:
//               FSM state codes, parameter defaults and CPU vector addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package intr_pkg;

    localparam int          c_NUM_SRC_DEFAULT     = 4;
    localparam int          c_ACK_TIMEOUT_DEFAULT = 7;

    localparam logic [1:0]  c_ST_IDLE     = 2'd0;
    localparam logic [1:0]  c_ST_ISSUE    = 2'd1;
    localparam logic [1:0]  c_ST_WAIT_ACK = 2'd2;
    localparam logic [1:0]  c_ST_SERVICE  = 2'd3;

    // CPU vector targets: an overflow exception pre-empts an external request.
    localparam logic [31:0] c_OVF_VECTOR  = 32'h0000_0300;
    localparam logic [31:0] c_EXT_VECTOR  = 32'h0000_0200;

endpackage
`default_nettype wire

// File: rtl/intr_req_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : intr_req_ctrl_if
// Description : Peripheral/CPU signal bundle of the interrupt request
//               controller; slave = controller, master = CPU/peripheral side.
// Revision    : 1.0 - initial release
// ============================================================================
interface intr_req_ctrl_if
    import intr_pkg::*;
#(
    parameter int NUM_SRC = c_NUM_SRC_DEFAULT
) ();

    localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] irq_src;
    logic [NUM_SRC-1:0] irq_mask;
    logic               cpu_busy;
    logic               cpu_ovf;
    logic               intr_ack;
    logic               ints_end;
    logic               external_intr;
    logic [ID_W-1:0]    intr_id;
    logic [NUM_SRC-1:0] pending;
    logic               in_service;

    modport slave (
        input  irq_src, irq_mask, cpu_busy, cpu_ovf, intr_ack, ints_end,
        output external_intr, intr_id, pending, in_service
    );

    modport master (
        output irq_src, irq_mask, cpu_busy, cpu_ovf, intr_ack, ints_end,
        input  external_intr, intr_id, pending, in_service
    );

endinterface
`default_nettype wire

// File: rtl/irq_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : irq_edge_det
// Description : Per-line rising-edge detector for synchronous interrupt lines.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_edge_det #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_src,
    output logic      [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] hist_q, hist_d;
    logic [WIDTH-1:0] armed_q, armed_d;

    // A line only arms once it has been seen low, so a level held through reset
    // release does not look like a fresh edge.
    always_comb begin
        hist_d  = i_src;
        armed_d = armed_q | ~i_src;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q  <= '0;
            armed_q <= '0;
        end else begin
            hist_q  <= hist_d;
            armed_q <= armed_d;
        end
    end

    assign o_rise = i_src & ~hist_q & armed_q;

endmodule
`default_nettype wire

// File: rtl/intr_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : intr_req_ctrl
// Description : Latches edge-triggered interrupt sources, arbitrates the lowest
//               unmasked index and runs the request/ack/service handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module intr_req_ctrl
    import intr_pkg::*;
#(
    parameter int NUM_SRC     = c_NUM_SRC_DEFAULT,
    parameter int ACK_TIMEOUT = c_ACK_TIMEOUT_DEFAULT
) (
    input  wire logic      clk,
    input  wire logic      rst,
    intr_req_ctrl_if.slave bus
);

    localparam int         ID_W           = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [2:0] c_TIMEOUT_LAST = 3'(ACK_TIMEOUT - 1);

    logic [1:0]         state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               ovf_seen_q, ovf_seen_d;

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_req;
    logic [NUM_SRC-1:0] w_clr;

    function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = ID_W'(i);
        end
    endfunction

    irq_edge_det #(
        .WIDTH (NUM_SRC)
    ) u_edge_det (
        .clk    (clk),
        .rst    (rst),
        .i_src  (bus.irq_src),
        .o_rise (w_rise)
    );

    assign w_req = pending_q & ~bus.irq_mask;

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        ovf_seen_d = ovf_seen_q;
        w_clr      = '0;
        case (state_q)
            c_ST_IDLE: begin
                if ((|w_req) && !bus.cpu_busy) begin
                    state_d = c_ST_ISSUE;
                    id_d    = lowest_idx(w_req);
                end
            end
            c_ST_ISSUE: begin
                cnt_d      = 3'd0;
                ovf_seen_d = bus.cpu_ovf;
                state_d    = c_ST_WAIT_ACK;
            end
            c_ST_WAIT_ACK: begin
                // An overflow steals the vector, so an ack after it is not ours.
                if (bus.cpu_ovf || ovf_seen_q) begin
                    state_d = c_ST_IDLE;
                end else if (bus.intr_ack) begin
                    state_d = c_ST_SERVICE;
                    w_clr   = {{(NUM_SRC-1){1'b0}}, 1'b1} << id_q;
                end else if (cnt_q == c_TIMEOUT_LAST) begin
                    state_d = c_ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            c_ST_SERVICE: begin
                if (bus.ints_end) state_d = c_ST_IDLE;
            end
            default: state_d = c_ST_IDLE;
        endcase
        // A new edge in the grant cycle outranks the clear.
        pending_d = (pending_q & ~w_clr) | w_rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_ST_IDLE;
            pending_q  <= '0;
            id_q       <= '0;
            cnt_q      <= 3'd0;
            ovf_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            ovf_seen_q <= ovf_seen_d;
        end
    end

    assign bus.external_intr = (state_q == c_ST_ISSUE) && !rst;
    assign bus.intr_id       = id_q;
    assign bus.pending       = pending_q;
    assign bus.in_service    = (state_q == c_ST_SERVICE);

endmodule
`default_nettype wire

// File: tb/tb_intr_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_intr_req_ctrl
// Description : Self-checking bench for intr_req_ctrl; request ids are queued
//               at stimulus time and matched against each external_intr pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intr_req_ctrl;

    localparam int NSRC = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   pulses;
    logic [1:0] exp_q[$];
    logic [1:0] exp_id;

    intr_req_ctrl_if #(.NUM_SRC(NSRC)) bus ();

    intr_req_ctrl #(
        .NUM_SRC     (NSRC),
        .ACK_TIMEOUT (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every request pulse seen at a falling edge must match the next queued id.
    always @(negedge clk) begin
        if (bus.external_intr === 1'b1) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got intr_id %0d, want no request", bus.intr_id);
            end else begin
                exp_id = exp_q.pop_front();
                if (bus.intr_id !== exp_id) begin
                    errors++;
                    $display("FAIL pulse_id: got %0d want %0d", bus.intr_id, exp_id);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_ext(input int max_cyc, output int n);
        n = 0;
        while (bus.external_intr !== 1'b1 && n < max_cyc) begin
            step();
            n++;
        end
        checks++;
        if (bus.external_intr !== 1'b1) begin
            errors++;
            $display("FAIL wait_ext: got no external_intr within %0d cycles, want a pulse", max_cyc);
        end
    endtask

    task automatic quiet();
        bus.irq_src = '0;
        step();
    endtask

    task automatic finish_service();
        step();
        bus.intr_ack = 1'b1;
        step();
        bus.intr_ack = 1'b0;
        chk("svc_in_service", {3'b0, bus.in_service}, 4'h1);
        bus.ints_end = 1'b1;
        step();
        bus.ints_end = 1'b0;
        chk("svc_end", {3'b0, bus.in_service}, 4'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        chk("reset_ext",     {3'b0, bus.external_intr}, 4'h0);
        chk("reset_id",      {2'b0, bus.intr_id},       4'h0);
        chk("reset_pending", bus.pending,               4'h0);
        chk("reset_insvc",   {3'b0, bus.in_service},    4'h0);
        rst = 1'b0;
        step();
        chk("post_reset_pending", bus.pending, 4'h0);
    endtask

    task automatic test_basic();
        quiet();
        bus.irq_src[2] = 1'b1;
        exp_q.push_back(2'd2);
        step();
        chk("basic_pending", bus.pending, 4'h4);
        chk("basic_no_ext_yet", {3'b0, bus.external_intr}, 4'h0);
        step();
        chk("basic_ext", {3'b0, bus.external_intr}, 4'h1);
        chk("basic_id",  {2'b0, bus.intr_id},       4'h2);
        step();
        chk("basic_ext_one_cycle", {3'b0, bus.external_intr}, 4'h0);
        bus.intr_ack = 1'b1;
        step();
        bus.intr_ack = 1'b0;
        chk("basic_ack_pending", bus.pending, 4'h0);
        chk("basic_in_service", {3'b0, bus.in_service}, 4'h1);
        bus.ints_end = 1'b1;
        step();
        bus.ints_end = 1'b0;
        chk("basic_end", {3'b0, bus.in_service}, 4'h0);
    endtask

    task automatic test_priority();
        int n;
        quiet();
        bus.irq_src = 4'b1010;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        step();
        chk("prio_pending", bus.pending, 4'hA);
        wait_ext(4, n);
        chk("prio_first_id", {2'b0, bus.intr_id}, 4'h1);
        step();
        bus.intr_ack = 1'b1;
        step();
        bus.intr_ack = 1'b0;
        chk("prio_pending_after_ack", bus.pending, 4'h8);
        chk("prio_id_held", {2'b0, bus.intr_id}, 4'h1);
        bus.ints_end = 1'b1;
        step();
        bus.ints_end = 1'b0;
        chk("prio_no_issue_in_idle", {3'b0, bus.external_intr}, 4'h0);
        wait_ext(4, n);
        chk("prio_second_id", {2'b0, bus.intr_id}, 4'h3);
        finish_service();
        chk("prio_pending_done", bus.pending, 4'h0);
    endtask

    task automatic test_ovf();
        int n;
        quiet();
        bus.irq_src[0] = 1'b1;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd0);
        wait_ext(4, n);
        step();
        bus.cpu_ovf  = 1'b1;
        bus.cpu_busy = 1'b1;
        step();
        bus.cpu_ovf  = 1'b0;
        bus.intr_ack = 1'b1;
        step();
        bus.intr_ack = 1'b0;
        chk("ovf_no_service", {3'b0, bus.in_service}, 4'h0);
        chk("ovf_pending_kept", bus.pending, 4'h1);
        repeat (3) step();
        chk("ovf_busy_holds", {3'b0, bus.external_intr}, 4'h0);
        bus.cpu_busy = 1'b0;
        wait_ext(4, n);
        chk("ovf_reissue_latency", n[3:0], 4'h1);
        chk("ovf_reissue_id", {2'b0, bus.intr_id}, 4'h0);
        finish_service();
    endtask

    task automatic test_timeout();
        int n;
        quiet();
        bus.irq_src[1] = 1'b1;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        wait_ext(4, n);
        step();
        wait_ext(20, n);
        chk("timeout_gap", n[3:0] + 4'd1, 4'd9);
        chk("timeout_id", {2'b0, bus.intr_id}, 4'h1);
        chk("timeout_pending", bus.pending, 4'h2);
        finish_service();
    endtask

    task automatic test_mask();
        int n;
        int seen;
        quiet();
        bus.irq_mask[0] = 1'b1;
        bus.irq_src[0]  = 1'b1;
        step();
        chk("mask_pending", bus.pending, 4'h1);
        seen = 0;
        repeat (5) begin
            step();
            if (bus.external_intr === 1'b1) seen++;
        end
        chk("mask_no_request", seen[3:0], 4'h0);
        bus.irq_mask[0] = 1'b0;
        exp_q.push_back(2'd0);
        wait_ext(4, n);
        chk("mask_clear_id", {2'b0, bus.intr_id}, 4'h0);
        // Masking after the request went out must not cancel it.
        bus.irq_mask[0] = 1'b1;
        finish_service();
        chk("mask_late_pending", bus.pending, 4'h0);
        bus.irq_mask = '0;
    endtask

    task automatic test_back_to_back();
        int n;
        quiet();
        bus.irq_src[2] = 1'b1;
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd2);
        wait_ext(4, n);
        bus.irq_src[2] = 1'b0;
        step();
        bus.irq_src[2] = 1'b1;
        bus.intr_ack   = 1'b1;
        step();
        bus.intr_ack   = 1'b0;
        chk("b2b_set_wins", bus.pending, 4'h4);
        chk("b2b_in_service", {3'b0, bus.in_service}, 4'h1);
        bus.ints_end = 1'b1;
        step();
        bus.ints_end = 1'b0;
        wait_ext(4, n);
        chk("b2b_retrigger_id", {2'b0, bus.intr_id}, 4'h2);
        finish_service();
        chk("b2b_pending_done", bus.pending, 4'h0);
    endtask

    task automatic test_reset_mid();
        int n;
        quiet();
        // Reset landing in the ISSUE cycle: the pulse must be suppressed.
        bus.irq_src[3] = 1'b1;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("rst_issue_ext", {3'b0, bus.external_intr}, 4'h0);
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("rst_issue_held_src", bus.pending, 4'h0);
        quiet();
        bus.irq_src[3] = 1'b1;
        exp_q.push_back(2'd3);
        wait_ext(4, n);
        step();
        rst = 1'b1;
        step();
        chk("rst_wait_ext",     {3'b0, bus.external_intr}, 4'h0);
        chk("rst_wait_id",      {2'b0, bus.intr_id},       4'h0);
        chk("rst_wait_pending", bus.pending,               4'h0);
        chk("rst_wait_insvc",   {3'b0, bus.in_service},    4'h0);
        rst = 1'b0;
        repeat (4) step();
        chk("rst_held_src_no_pending", bus.pending, 4'h0);
        quiet();
        bus.irq_src[3] = 1'b1;
        step();
        chk("rst_rearm_pending", bus.pending, 4'h8);
        exp_q.push_back(2'd3);
        wait_ext(4, n);
        finish_service();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pulses = 0;
        rst           = 1'b1;
        bus.irq_src   = '0;
        bus.irq_mask  = '0;
        bus.cpu_busy  = 1'b0;
        bus.cpu_ovf   = 1'b0;
        bus.intr_ack  = 1'b0;
        bus.ints_end  = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_ovf();
        test_timeout();
        test_mask();
        test_back_to_back();
        test_reset_mid();
        quiet();
        step();
        chk("queue_drained", exp_q.size() > 0 ? 4'h1 : 4'h0, 4'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 ns, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
